store_arbiter: RTL and testbench

STORE_ARBITER -- requirements
Module: store_arbiter

---
 rtl/store_arbiter.sv | 127 ++++++++++++
 tb/tb_store_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_arbiter.sv
// store_arbiter: grants one of NREQ requesters per write, drives the captured
// data word and a one-cycle store strobe into a downstream store register,
// then returns a one-cycle ack to the winner. At most one write every 3 cycles.
//
// Compile-time option:
//   STORE_ARB_ROUND_ROBIN_EN  defined   -> round-robin search starting at rr_ptr
//                             undefined -> fixed priority, req[0] highest
//
// The arbitration search uses a 2-bit index, so NREQ is expected to be 4.
module store_arbiter #(
  parameter int DATA_W = 8,
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data_in,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      mem_data,
  output logic                   mem_store,
  output logic                   busy,
  output logic [1:0]             last_grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_winner;
  logic [NREQ-1:0]     r_ack;
  logic [DATA_W-1:0]   r_mem_data;
  logic                r_mem_store;
  logic                r_busy;
  logic [1:0]          r_last_grant;
`ifdef STORE_ARB_ROUND_ROBIN_EN
  logic [1:0]          r_rr_ptr;
`endif

  logic                w_any;
  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic [DATA_W-1:0]   w_slice [NREQ];

  // Unpack the flat data bus into one word per requester
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_slice[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  // Winner search: first requester found walking upward from the start index
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    w_idx = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef STORE_ARB_ROUND_ROBIN_EN
      // 2-bit add wraps naturally, giving the modulo-4 walk from the pointer
      w_idx = r_rr_ptr + 2'(k);
`else
      w_idx = 2'(k);
`endif
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Write-sequencing FSM; every output is registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_winner     <= 2'd0;
      r_ack        <= '0;
      r_mem_data   <= '0;
      r_mem_store  <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= 2'd0;
`ifdef STORE_ARB_ROUND_ROBIN_EN
      r_rr_ptr     <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Data is captured at the grant edge only, so later data_in
          // movement cannot disturb the word being stored.
          if (w_any) begin
            r_winner     <= w_win;
            r_last_grant <= w_win;
            r_mem_data   <= w_slice[w_win];
            r_mem_store  <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_WRITE;
`ifdef STORE_ARB_ROUND_ROBIN_EN
            r_rr_ptr     <= w_win + 2'd1;
`endif
          end
        end
        S_WRITE: begin
          r_mem_store <= 1'b0;
          r_ack       <= NREQ'(1) << r_winner;
          r_state     <= S_ACK;
        end
        S_ACK: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack       <= '0;
          r_mem_store <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign ack        = r_ack;
  assign mem_data   = r_mem_data;
  assign mem_store  = r_mem_store;
  assign busy       = r_busy;
  assign last_grant = r_last_grant;

endmodule

// File: tb/tb_store_arbiter.sv
// tb_store_arbiter: directed scenarios plus randomized traffic, each cycle
// checked against a transaction-timing reference model.
module tb_store_arbiter;
  localparam int DATA_W = 8;
  localparam int NREQ   = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*DATA_W-1:0] data_in = '0;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      mem_data;
  logic                   mem_store;
  logic                   busy;
  logic [1:0]             last_grant;

  store_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .ack(ack), .mem_data(mem_data), .mem_store(mem_store),
    .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: e = rising edges seen, g = edge at which the current
  // write was granted. Store strobe is visible right after edge g, ack right
  // after edge g+1, and the next grant may happen at edge g+3 or later.
  int         e = 0;
  int         g = -1000;
  logic [1:0] m_win  = 2'd0;
  logic [1:0] m_last = 2'd0;
  logic [1:0] m_ptr  = 2'd0;
  logic [7:0] m_data = 8'h00;
  logic [3:0] q_ack[$];

  function automatic logic [1:0] pick(logic [3:0] r, logic [1:0] p);
`ifdef STORE_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (int'(p) + k) % 4;
      if (r[i]) return 2'(i);
    end
`else
    for (int k = 0; k < 4; k++)
      if (r[k]) return 2'(k);
`endif
    return 2'd0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    g = -1000; m_win = 2'd0; m_last = 2'd0; m_ptr = 2'd0; m_data = 8'h00;
  endtask

  task automatic model_edge();
    e++;
    if (reset) model_reset();
    else if (e >= g + 3 && req != 4'b0) begin
      m_win  = pick(req, m_ptr);
      g      = e;
      m_last = m_win;
      m_data = data_in[int'(m_win)*8 +: 8];
      m_ptr  = m_win + 2'd1;
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_ack;
    exp_ack = (e == g + 1) ? (4'b0001 << m_win) : 4'b0000;
    chk("mem_store",  {31'b0, mem_store}, {31'b0, (e == g)});
    chk("ack",        {28'b0, ack}, {28'b0, exp_ack});
    chk("busy",       {31'b0, busy}, {31'b0, (e == g) || (e == g + 1)});
    chk("mem_data",   {24'b0, mem_data}, {24'b0, m_data});
    chk("last_grant", {30'b0, last_grant}, {30'b0, m_last});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (ack != 4'b0) q_ack.push_back(ack);
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    req   = 4'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    reset = 1'b0;
    q_ack.delete();
  endtask

  initial begin
    // Reset state before any clock edge
    #1;
    chk("rst_store", {31'b0, mem_store}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_ack",   {28'b0, ack}, 32'd0);
    chk("rst_data",  {24'b0, mem_data}, 32'd0);
    chk("rst_lg",    {30'b0, last_grant}, 32'd0);
    hard_reset();

    // Single request from requester 2
    req = 4'b0100;
    data_in = {8'h11, 8'hA5, 8'h22, 8'h33};
    tick();
    chk("t28_store", {31'b0, mem_store}, 32'd1);
    chk("t28_data",  {24'b0, mem_data}, 32'hA5);
    chk("t28_busy1", {31'b0, busy}, 32'd1);
    req = 4'b0;
    tick();
    chk("t28_ack",   {28'b0, ack}, 32'b0100);
    chk("t28_busy2", {31'b0, busy}, 32'd1);
    tick();
    chk("t28_idle",  {31'b0, busy}, 32'd0);

    // All/two requesters held: arbitration order
    hard_reset();
`ifdef STORE_ARB_ROUND_ROBIN_EN
    req = 4'b1111;
`else
    req = 4'b1010;
`endif
    repeat (24) begin
      data_in = $urandom;
      tick();
    end
    req = 4'b0;
    chk("order_cnt", q_ack.size(), 32'd8);
    for (int i = 0; i < q_ack.size(); i++) begin
`ifdef STORE_ARB_ROUND_ROBIN_EN
      chk("rr_order", {28'b0, q_ack[i]}, 32'd1 << (i % 4));
`else
      chk("fp_order", {28'b0, q_ack[i]}, 32'b0010);
`endif
    end

    // Data stability after the grant edge
    hard_reset();
    req = 4'b0001;
    data_in = {24'h5A5A5A, 8'h3C};
    tick();
    chk("t31_grant", {24'b0, mem_data}, 32'h3C);
    data_in[7:0] = 8'hFF;
    tick();
    chk("t31_write", {24'b0, mem_data}, 32'h3C);
    req = 4'b0;
    tick();
    tick();
    chk("t31_idle",  {24'b0, mem_data}, 32'h3C);

    // Asynchronous reset mid-WRITE aborts the write
    hard_reset();
    req = 4'b0010;
    data_in = {8'h00, 8'h00, 8'h5A, 8'h00};
    tick();
    chk("t32_store", {31'b0, mem_store}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t32_store0", {31'b0, mem_store}, 32'd0);
    chk("t32_busy0",  {31'b0, busy}, 32'd0);
    chk("t32_data0",  {24'b0, mem_data}, 32'd0);
    check_all();
    tick();
    reset = 1'b0;
    req = 4'b0;
    q_ack.delete();
    repeat (4) tick();
    chk("t32_noack", q_ack.size(), 32'd0);

`ifdef STORE_ARB_ROUND_ROBIN_EN
    // Pointer wrap from 3 back to 0
    hard_reset();
    req = 4'b1000;
    tick();
    req = 4'b0;
    tick();
    tick();
    q_ack.delete();
    req = 4'b1001;
    repeat (6) tick();
    req = 4'b0;
    chk("wrap_cnt", q_ack.size(), 32'd2);
    if (q_ack.size() == 2) begin
      chk("wrap_first",  {28'b0, q_ack[0]}, 32'b0001);
      chk("wrap_second", {28'b0, q_ack[1]}, 32'b1000);
    end
`endif

    // Randomized traffic with occasional asynchronous resets
    hard_reset();
    for (int n = 0; n < 600; n++) begin
      req = ($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom_range(0, 15));
      data_in = $urandom;
      tick();
      if ($urandom_range(0, 59) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
